// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: streams every W-bit word with popcount k in ascending order over valid/ready
module ones_pattern_gen #(
  parameter int W = 8,
  localparam int KW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_word,
  output logic          out_last,
  output logic [W-1:0]  out_idx,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
  state_t state, state_n;
  logic [W-1:0] lo, hi, hi_q, hi_n, low_bit, sum, nxt, word_n, idx_n;
  logic [KW-1:0] tz;
  logic last_n, err_n;
  assign busy = state != IDLE;
  assign out_valid = state == EMIT;
  assign done = state == FIN;
  // Gosper step: lowest set bit ripples the trailing block up; leftover ones are right-justified
  always_comb begin
    lo = ~({W{1'b1}} << k);
    hi = ~({W{1'b1}} >> k);
    low_bit = out_word & (~out_word + 1'b1);
    sum = out_word + low_bit;
    tz = '0;
    for (int i = W - 1; i >= 0; i--) if (low_bit[i]) tz = KW'(i);
    nxt = (((sum ^ out_word) >> 2) >> tz) | sum;
  end
  always_comb begin
    state_n = state;
    word_n = out_word;
    idx_n = out_idx;
    last_n = out_last;
    hi_n = hi_q;
    err_n = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        if (k > KW'(W)) err_n = 1'b1;
        else begin
          state_n = EMIT;
          word_n = lo;
          idx_n = '0;
          hi_n = hi;
          last_n = lo == hi;
        end
      end
      EMIT: if (out_ready) begin
        if (out_last) state_n = FIN;
        else begin
          word_n = nxt;
          idx_n = out_idx + 1'b1;
          last_n = nxt == hi_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_word <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
      hi_q <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      out_word <= word_n;
      out_idx <= idx_n;
      out_last <= last_n;
      hi_q <= hi_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: randomized scoreboard bench against an enumerate-and-filter reference model
module tb_ones_pattern_gen;
  localparam int W = 8;
  localparam int KW = $clog2(W) + 1;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [KW-1:0] k = '0;
  logic busy, out_valid, out_last, done, err;
  logic [W-1:0] out_word, out_idx;
  typedef struct packed {logic [W-1:0] word; logic [W-1:0] idx; logic last;} exp_t;
  exp_t q[$];
  exp_t held;
  int checks = 0, passed = 0, acc_cnt = 0, done_cnt = 0, err_cnt = 0;
  bit rand_ready = 0, pend_done = 0, pend_idle = 0, stall = 0;

  ones_pattern_gen #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .out_idx(out_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference: scan all words in numeric order, keep those with the requested popcount
  task automatic push_model(int kk);
    exp_t e, t;
    int n = 0;
    for (int v = 0; v < (1 << W); v++)
      if ($countones(v) == kk) begin
        e.word = W'(v);
        e.idx = W'(n);
        e.last = 1'b0;
        q.push_back(e);
        n++;
      end
    t = q.pop_back();
    t.last = 1'b1;
    q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 0;
      pend_done = 0;
      pend_idle = 0;
    end else begin
      if (pend_idle) begin
        chk("busy_drop", busy, 0);
        pend_idle = 0;
      end
      if (pend_done) begin
        chk("done_pulse", done, 1);
        chk("busy_in_fin", busy, 1);
        pend_done = 0;
        pend_idle = 1;
      end else if (done) chk("done_spurious", done, 0);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (stall && out_valid) chk("stall_hold", {out_word, out_idx, out_last}, held);
      stall = out_valid && !out_ready;
      held = {out_word, out_idx, out_last};
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL extra_word: got %0h expected none", out_word);
        else begin
          passed++;
          chk("word", out_word, q[0].word);
          chk("idx", out_idx, q[0].idx);
          chk("last", out_last, q[0].last);
          void'(q.pop_front());
        end
        acc_cnt++;
        if (out_last) pend_done = 1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic go(int kk);
    @(posedge clk);
    #1 start = 1;
    k = KW'(kk);
    if (kk <= W) push_model(kk);
    @(posedge clk);
    #1 start = 0;
    if (kk <= W) begin
      chk("busy_latency", busy, 1);
      chk("valid_latency", out_valid, 1);
      chk("first_word", out_word, (1 << kk) - 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base, n;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1;
    go(2);
    wait_idle();
    go(0);
    wait_idle();
    go(W);
    wait_idle();
    go(W + 1);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", out_valid, 0);
    @(posedge clk);
    #1 chk("err_one_cycle", err, 0);
    chk("err_still_idle", busy, 0);
    rand_ready = 1;
    base = acc_cnt;
    go(3);
    wait_idle();
    rand_ready = 0;
    chk("k3_count", acc_cnt - base, 56);
    chk("k3_drained", q.size(), 0);
    go(2);
    repeat (5) @(posedge clk);
    #1 start = 1;
    k = KW'(1);
    @(posedge clk);
    #1 start = 0;
    chk("no_err_when_busy", err, 0);
    wait_idle();
    chk("busy_start_drained", q.size(), 0);
    chk("err_count", err_cnt, 1);
    go(4);
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 10 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("reset_wait", acc_cnt >= base + 10, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_word", out_word, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_last", out_last, 0);
    chk("arst_done", done, 0);
    q.delete();
    @(negedge clk) rst_n = 1;
    go(1);
    wait_idle();
    chk("done_count", done_cnt, 6);
    chk("final_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
- Inverse companion of the population counter.
- Given a target ones-count K, sequentially emits every W-bit word whose popcount equals K, in strictly ascending numerical order.
- Output is a valid/ready stream.
- Used as a stimulus source for popcount checkers and for combination enumeration in the test infrastructure.

Parameters:
W, 8, word width; legal range 2..16.
KW, $clog2(W)+1, width of the K input and popcount range (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new enumeration; sampled only in IDLE.
k  input  KW  target number of ones; sampled with start.
busy  output  1  high from start acceptance until the done pulse, inclusive.
out_valid  output  1  out_word holds a valid pattern.
out_ready  input  1  downstream accepts the current word when high with out_valid.
out_word  output  W  current pattern, popcount(out_word)==K always.
out_last  output  1  qualifies out_word as the final pattern (numerically largest).
out_idx  output  W  zero-based index of the current pattern in the sequence.
done  output  1  one-cycle pulse after the last word is accepted.
err  output  1  one-cycle pulse when start is given with k>W.

Behaviour:
- Reset values: busy=0, out_valid=0, out_word=0, out_last=0, out_idx=0, done=0, err=0, state=IDLE.
- Reset is asynchronous and may assert mid-enumeration; the stream aborts with no done pulse.
- The FSM has three states:
  - IDLE:
    - start=1 with k<=W: load out_word with the K lowest bits set (2^K-1), out_idx=0, and go to EMIT. busy, out_valid and out_word are visible the cycle after start (latency 1).
    - start=1 with k>W: err=1 for one cycle, stay in IDLE, emit no words.
  - EMIT:
    - out_valid=1.
    - While out_valid && !out_ready, out_word, out_last and out_idx hold stable.
    - On a handshake of a non-last word: out_word advances to the next larger W-bit value with the same popcount, and out_idx increments. The next word is valid the following cycle, giving one word per cycle under continuous ready.
    - On a handshake with out_last=1: go to FIN with out_valid=0.
  - FIN: done=1 for exactly one cycle, busy=1, then return to IDLE with busy=0.
- out_last is registered and true exactly when out_word equals the K highest bits set ((2^K-1) << (W-K)).
- Boundary cases:
  - K=0: a single word 0 with out_last=1.
  - K=W: a single all-ones word with out_last=1.
- The number of words emitted equals C(W,K). The final out_idx is C(W,K)-1, which always fits in W bits.
- Next-pattern computation must not use a general divider.
  - Permitted approaches: lowest-set-bit / carry-propagate plus shift by the trailing-zero count, or any equivalent.
  - The computation must be single-cycle at the chosen W.
- start while busy (EMIT or FIN) is ignored and err is not raised.
- out_ready while out_valid=0 has no effect.
- An out_ready held high across FIN does not consume anything.

Test Plan:
- W=4, start k=2, out_ready=1 -> out_word sequence 0011,0101,0110,1001,1010,1100. out_idx runs 0..5. out_last only on 1100. done pulses the cycle after 1100 is accepted. busy drops the following cycle.
- W=4, k=0 then k=4 -> a single word 0000 and a single word 1111, each with out_last=1 and out_idx=0, each followed by a done pulse.
- W=4, k=5 -> err pulses once, out_valid stays 0, busy stays 0, no done.
- W=8, k=3, out_ready toggled pseudo-randomly -> 56 words, all ascending, each popcount 3. Every word is held stable while stalled, none is dropped or duplicated, and the final word is 11100000.
- Assert rst_n=0 mid-run (W=8, k=4, after 10 words) -> all outputs return to their reset values immediately with no done. A fresh start k=1 then yields 00000001 first.
- Pulse start with k=1 during EMIT of a k=2 run -> the current run completes unaltered, with no err.
